prio_enc_rr: RTL

- Parametrised N-to-log2(N) encoder that generalises the fixed 8-to-3 octal encoder.
- Resolves multi-hot inputs by fixed priority or by round-robin priority.
- Registered output with a valid/ready handshake on both sides.
- Used wherever a request vector must become a single index: arbiters, interrupt encoders, one-hot state decoding.

---
 rtl/prio_enc_rr.sv | 115 +++++++++++
 1 files changed

// File: rtl/prio_enc_rr.sv
// N-to-log2(N) priority encoder with fixed or round-robin resolution and a registered valid/ready output.
// Optional ONEHOT_ERR_EN adds an err output flagging multi-hot accepted vectors.
module prio_enc_rr #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] y,
    output logic         none,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ONEHOT_ERR_EN
    ,
    output logic         err
`endif
);

    logic [W-1:0] y_q, y_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         none_q, none_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] fix_idx, hi_idx, lo_idx, enc_idx, ptr_nxt;
    logic         hi_found;
    logic         accept;

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // single output register frees up in the same cycle it is drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) fix_idx = W'(i);
        end
    end

    // Round-robin: lowest set index at or above ptr, else lowest set index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (d[i]) begin
                lo_idx = W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_idx   = W'(i);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign enc_idx = mode ? (hi_found ? hi_idx : lo_idx) : fix_idx;
    assign ptr_nxt = (enc_idx == W'(N - 1)) ? '0 : enc_idx + W'(1);

`ifdef ONEHOT_ERR_EN
    logic err_q, err_d;
    logic multi_hot;

    assign multi_hot = |(d & (d - {{(N-1){1'b0}}, 1'b1}));
    assign err       = err_q;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        none_d      = none_q;
        ptr_d       = ptr_q;
`ifdef ONEHOT_ERR_EN
        err_d       = err_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = enc_idx;
            none_d      = ~|d;
`ifdef ONEHOT_ERR_EN
            err_d       = multi_hot;
`endif
            if (mode && |d) ptr_d = ptr_nxt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            none_q      <= 1'b0;
            ptr_q       <= '0;
`ifdef ONEHOT_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            none_q      <= none_d;
            ptr_q       <= ptr_d;
`ifdef ONEHOT_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    assign y         = y_q;
    assign none      = none_q;
    assign out_valid = out_valid_q;

endmodule
